store_merge_unit: RTL
=====================

// Module: store_merge_unit
// PURPOSE
// Store-side counterpart of the load sign/zero extension path: narrows a 32-bit register
// value to byte/halfword/word and merges it into a word-addressed data memory.
// Sub-word stores (SB/SH) use a read-modify-write FSM; word stores (SW) write directly.
// Sits between the store datapath and the data memory port; the controller stalls while busy=1.
// PARAMETERS
// ADDR_W      32  byte-address width; memory is word-addressed by addr[ADDR_W-1:2]
// BIG_ENDIAN  0   0: byte k at bits [8k+7:8k]; 1: byte k at bits [31-8k -: 8]
// PORTS
// clk         in   1       rising-edge clock
// rst_n       in   1       asynchronous active-low reset
// start       in   1       request pulse; sampled only in IDLE
// size        in   2       00 byte, 01 halfword, 10 word, 11 reserved
// addr        in   ADDR_W  byte address of the store
// wdata       in   32      register value; low byte/half used for SB/SH
// busy        out  1       1 in any state other than IDLE
// done        out  1       1-cycle pulse: store completed
// misaligned  out  1       1-cycle pulse: request rejected, no memory access
// mem_addr    out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
// mem_re      out  1       memory read strobe; mem_rdata valid the following cycle
// mem_rdata   in   32      memory read data
// mem_we      out  1       memory write strobe
// mem_wdata   out  32      merged word to write
// BEHAVIOUR
// - Reset (async, any state): state=IDLE; busy, done, misaligned, mem_re, mem_we = 0;
//   mem_addr, mem_wdata, captured request registers = 0.
// - States: IDLE, READ, MERGE, WRITE, DONE, ERR. All outputs registered/decoded from state.
// - IDLE: on start=1 capture size, addr, wdata. Alignment check at capture:
//   half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> ERR; word -> WRITE; else READ.
// - READ (1 cycle): mem_re=1, mem_addr valid. -> MERGE.
// - MERGE (1 cycle): mem_rdata sampled; replace selected lane(s) with wdata[7:0] (byte at
//   addr[1:0]) or wdata[15:0] (half at addr[1]); other lanes unchanged. -> WRITE.
// - WRITE (1 cycle): mem_we=1, mem_wdata = merged word (or wdata for SW). -> DONE.
// - DONE: done=1 one cycle -> IDLE. ERR: misaligned=1 one cycle, mem_re=mem_we=0 -> IDLE.
// - Latency from start edge T: SB/SH done at T+4; SW done at T+2; misaligned at T+1.
// - start while busy=1 ignored (not queued); new start accepted in the cycle after DONE/ERR.
// - addr/wdata/size may change after capture without effect.
// - Reset during WRITE aborts the store; mem_we drops asynchronously, memory untouched.
// - Halfword lane in BIG_ENDIAN=1: addr[1]=0 -> bits[31:16], addr[1]=1 -> bits[15:0].
// TESTING
// 1. LE, mem[0x10]=0xAABBCCDD; SB addr=0x11 wdata=0x12345678 -> mem_re at T+1,
//    mem_we at T+3 with mem_wdata=0xAABB78DD, done at T+4.
// 2. LE, mem[0x10]=0xAABBCCDD; SH addr=0x12 wdata=0x0000BEEF -> writes 0xBEEFCCDD.
// 3. SW addr=0x10 wdata=0xCAFEF00D -> mem_re never 1, mem_we at T+1, done at T+2.
// 4. SH addr=0x13 and SW addr=0x12 and size=11 -> misaligned pulse at T+1, no mem_re/mem_we,
//    busy low at T+2.
// 5. start re-pulsed during READ -> ignored, exactly one write; rst_n=0 during MERGE ->
//    all outputs 0 immediately, no write, next request completes normally.
// 6. BIG_ENDIAN=1, mem[0x10]=0xAABBCCDD; SB addr=0x11 wdata=0x78 -> writes 0xAA78CCDD.

Source files
------------

// File: rtl/store_merge_unit.sv
// store_merge_unit
// Narrows a 32-bit register value to byte/halfword/word and merges it into a
// word-addressed data memory. Sub-word stores (SB/SH) run a read-modify-write
// sequence; word stores (SW) write the word directly. Misaligned or reserved-size
// requests are rejected with a one-cycle misaligned pulse and no memory access.
// All outputs are registers updated together with the state register, so each
// output reflects the state the FSM has just entered.

module store_merge_unit #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              misaligned,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    output logic              mem_we,
    output logic [31:0]       mem_wdata
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_MERGE = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t            state_r;
    logic [1:0]        size_r;
    logic [1:0]        offset_r;
    logic [15:0]       wdata_r;
    logic              busy_r;
    logic              done_r;
    logic              misaligned_r;
    logic              mem_re_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;

    // A request is rejected when the store would straddle a word lane boundary
    // or uses the reserved size encoding.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic bad;
        case (sz)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    // Replace the addressed byte or halfword lane of the old word; other lanes
    // pass through. Big-endian mirrors the lane numbering within the word.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  off,
                                                input logic [15:0] data);
        logic [31:0] res;
        logic [1:0]  byte_lane;
        logic        half_lane;
        res       = old_word;
        byte_lane = BIG_ENDIAN ? (2'd3 - off) : off;
        half_lane = BIG_ENDIAN ? ~off[1] : off[1];
        case (sz)
            SZ_BYTE: res[{byte_lane, 3'b000} +: 8]   = data[7:0];
            SZ_HALF: res[{half_lane, 4'b0000} +: 16] = data;
            default: res = old_word;
        endcase
        return res;
    endfunction

    // Store sequencing FSM: captures the request, drives the memory strobes and
    // raises the completion/rejection pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            size_r       <= 2'b00;
            offset_r     <= 2'b00;
            wdata_r      <= 16'h0000;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            mem_re_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= '0;
            mem_wdata_r  <= 32'h0000_0000;
        end else begin
            done_r       <= 1'b0;
            misaligned_r <= 1'b0;
            mem_re_r     <= 1'b0;
            mem_we_r     <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        size_r     <= size;
                        offset_r   <= addr[1:0];
                        wdata_r    <= wdata[15:0];
                        mem_addr_r <= {addr[ADDR_W-1:2], 2'b00};
                        busy_r     <= 1'b1;
                        if (is_misaligned(size, addr[1:0])) begin
                            state_r      <= S_ERR;
                            misaligned_r <= 1'b1;
                        end else if (size == SZ_WORD) begin
                            state_r     <= S_WRITE;
                            mem_we_r    <= 1'b1;
                            mem_wdata_r <= wdata;
                        end else begin
                            state_r  <= S_READ;
                            mem_re_r <= 1'b1;
                        end
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                S_READ: begin
                    // Memory returns the old word during MERGE.
                    state_r <= S_MERGE;
                end
                S_MERGE: begin
                    state_r     <= S_WRITE;
                    mem_we_r    <= 1'b1;
                    mem_wdata_r <= merge_lanes(mem_rdata, size_r, offset_r, wdata_r);
                end
                S_WRITE: begin
                    state_r <= S_DONE;
                    done_r  <= 1'b1;
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                S_ERR: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign misaligned = misaligned_r;
    assign mem_re     = mem_re_r;
    assign mem_we     = mem_we_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;

endmodule
